// File: rtl/clken_gen_pkg.sv
// Shared types and helpers for the multi-channel fractional clock-enable generator.
package clken_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RUN    = 2'd2,
    SWITCH = 2'd3
  } state_t;

  localparam logic MODE_A = 1'b0;
  localparam logic MODE_B = 1'b1;

  localparam int MAX_CH       = 8;
  localparam int MAX_ACC_W    = 32;
  localparam int MAX_PACKED_W = MAX_CH * MAX_ACC_W;

  // Extract the w-bit field of channel ch from a packed per-channel vector.
  function automatic logic [MAX_ACC_W-1:0] ch_field(
    input logic [MAX_PACKED_W-1:0] vec,
    input int unsigned             ch,
    input int unsigned             w
  );
    logic [MAX_PACKED_W-1:0] shifted;
    logic [MAX_ACC_W-1:0]    mask;
    shifted = vec >> (ch * w);
    mask    = (MAX_ACC_W'(1) << w) - MAX_ACC_W'(1);
    return shifted[MAX_ACC_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/clken_nco_ch.sv
// One fractional-ratio accumulator: emits a registered single-cycle enable at rate inc/mod.
module clken_nco_ch #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [ACC_W-1:0] inc_i,
  input  logic [ACC_W-1:0] mod_i,
  output logic             ce_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;

  // One extra bit so acc+inc never wraps before the modulus compare.
  assign sum  = {1'b0, acc_q} + {1'b0, inc_i};
  assign diff = sum - {1'b0, mod_i};

  always_comb begin
    acc_d = acc_q;
    ce_d  = 1'b0;
    if (clear_i) begin
      acc_d = '0;
    end else if (advance_i) begin
      if (sum >= {1'b0, mod_i}) begin
        acc_d = diff[ACC_W-1:0];
        ce_d  = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/clken_gen_multi.sv
// Multi-channel clock-enable generator with lock qualification and glitch-free A/B ratio switching.
module clken_gen_multi
  import clken_gen_pkg::*;
#(
  parameter int                      NUM_CH    = 3,
  parameter int                      ACC_W     = 16,
  parameter int                      LOCK_WAIT = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INC_A     = {16'd1, 16'd1, 16'd1},
  parameter logic [NUM_CH*ACC_W-1:0] MOD_A     = {16'd24, 16'd4, 16'd12},
  parameter logic [NUM_CH*ACC_W-1:0] INC_B     = {16'd1, 16'd1, 16'd1},
  parameter logic [NUM_CH*ACC_W-1:0] MOD_B     = {16'd32, 16'd5, 16'd16}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              mode_sel,
  output logic [NUM_CH-1:0] ce,
  output logic              running,
  output logic              mode_active,
  output logic              switch_done
);

  localparam int                CNT_W    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_WAIT - 1);
  localparam logic [ACC_W-1:0]  INC0_A   = ACC_W'(ch_field(MAX_PACKED_W'(INC_A), 0, ACC_W));
  localparam logic [ACC_W-1:0]  INC0_B   = ACC_W'(ch_field(MAX_PACKED_W'(INC_B), 0, ACC_W));

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("clken_gen_multi: NUM_CH must be 1..8");
  end
  if (ACC_W < 1 || ACC_W > MAX_ACC_W) begin : g_bad_acc_w
    $error("clken_gen_multi: ACC_W must be 1..32");
  end
  if (LOCK_WAIT < 1) begin : g_bad_lock_wait
    $error("clken_gen_multi: LOCK_WAIT must be at least 1");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              lk_meta_q, lk_q;
  logic              running_q, switch_done_q;
  logic              advance;
  logic [ACC_W-1:0]  inc0_active;
  logic [NUM_CH-1:0] ce_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_q      <= lk_meta_q;
    end
  end

  assign inc0_active = (mode_q == MODE_B) ? INC0_B : INC0_A;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (lk_q) state_d = WAIT;
      end
      WAIT: begin
        if (!lk_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          mode_d  = mode_sel;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        // Switch only on a channel-0 boundary so no channel sees a truncated period.
        if (!lk_q) begin
          state_d = IDLE;
        end else if ((mode_sel != mode_q) && (ce_ch[0] || (inc0_active == '0))) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        mode_d  = mode_sel;
        state_d = lk_q ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mode_q        <= MODE_A;
      running_q     <= 1'b0;
      switch_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      running_q     <= (state_d == RUN);
      switch_done_q <= (state_q == SWITCH) && (state_d == RUN);
    end
  end

  // Channels advance only when staying in RUN, so a registered ce never leaks into a non-RUN cycle.
  assign advance = (state_q == RUN) && (state_d == RUN);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [ACC_W-1:0] INC_A_CH = ACC_W'(ch_field(MAX_PACKED_W'(INC_A), gi, ACC_W));
    localparam logic [ACC_W-1:0] MOD_A_CH = ACC_W'(ch_field(MAX_PACKED_W'(MOD_A), gi, ACC_W));
    localparam logic [ACC_W-1:0] INC_B_CH = ACC_W'(ch_field(MAX_PACKED_W'(INC_B), gi, ACC_W));
    localparam logic [ACC_W-1:0] MOD_B_CH = ACC_W'(ch_field(MAX_PACKED_W'(MOD_B), gi, ACC_W));

    if (MOD_A_CH == '0 || INC_A_CH > MOD_A_CH) begin : g_bad_a
      $error("clken_gen_multi: illegal mode A ratio on a channel");
    end
    if (MOD_B_CH == '0 || INC_B_CH > MOD_B_CH) begin : g_bad_b
      $error("clken_gen_multi: illegal mode B ratio on a channel");
    end

    logic [ACC_W-1:0] inc_sel;
    logic [ACC_W-1:0] mod_sel;
    assign inc_sel = (mode_q == MODE_B) ? INC_B_CH : INC_A_CH;
    assign mod_sel = (mode_q == MODE_B) ? MOD_B_CH : MOD_A_CH;

    clken_nco_ch #(
      .ACC_W(ACC_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (!advance),
      .advance_i(advance),
      .inc_i    (inc_sel),
      .mod_i    (mod_sel),
      .ce_o     (ce_ch[gi])
    );
  end

  assign ce          = ce_ch;
  assign running     = running_q;
  assign mode_active = mode_q;
  assign switch_done = switch_done_q;

endmodule

// File: tb/tb_clken_gen_multi.sv
// Directed bench: lock qualification, integer/fractional ratios, A/B switching, lock loss, async reset.
module tb_clken_gen_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       mode_sel;
  logic [2:0] ce;
  logic       running;
  logic       mode_active;
  logic       switch_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Mode A: ch0 1/12, ch1 1/4, ch2 3/8.  Mode B: ch0 1/16, ch1 1/5, ch2 disabled.
  clken_gen_multi #(
    .NUM_CH   (3),
    .ACC_W    (16),
    .LOCK_WAIT(16),
    .INC_A    ({16'd3, 16'd1, 16'd1}),
    .MOD_A    ({16'd8, 16'd4, 16'd12}),
    .INC_B    ({16'd0, 16'd1, 16'd1}),
    .MOD_B    ({16'd32, 16'd5, 16'd16})
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .mode_sel   (mode_sel),
    .ce         (ce),
    .running    (running),
    .mode_active(mode_active),
    .switch_done(switch_done)
  );

  typedef struct {
    int         off;
    logic [2:0] ce;
  } vec_t;

  vec_t tbl_a[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Waits for running to rise after lock; returns cycles taken (0 on timeout) and whether ce moved.
  task automatic wait_running(output int n, output bit ce_seen);
    n       = 0;
    ce_seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (ce != 3'b000) ce_seen = 1'b1;
      if (running) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int         n;
    bit         ce_seen;
    bit         bad;
    int         c0, c1, c2;
    int         ce0_at;
    logic [2:0] exp;

    tbl_a[0]  = '{3,  3'b100};
    tbl_a[1]  = '{4,  3'b010};
    tbl_a[2]  = '{6,  3'b100};
    tbl_a[3]  = '{8,  3'b110};
    tbl_a[4]  = '{11, 3'b100};
    tbl_a[5]  = '{12, 3'b011};
    tbl_a[6]  = '{14, 3'b100};
    tbl_a[7]  = '{16, 3'b110};
    tbl_a[8]  = '{19, 3'b100};
    tbl_a[9]  = '{20, 3'b010};
    tbl_a[10] = '{22, 3'b100};
    tbl_a[11] = '{24, 3'b111};

    rst_n      = 1'b0;
    pll_locked = 1'b0;
    mode_sel   = 1'b0;
    repeat (3) step();
    check("rst_ce", {29'd0, ce}, 0);
    check("rst_running", {31'd0, running}, 0);
    check("rst_mode_active", {31'd0, mode_active}, 0);
    check("rst_switch_done", {31'd0, switch_done}, 0);
    $display("reset: ce=%b running=%b", ce, running);

    rst_n = 1'b1;
    repeat (4) step();
    check("idle_running", {31'd0, running}, 0);

    pll_locked = 1'b1;
    wait_running(n, ce_seen);
    check_range("lock_latency", n, 17, 19);
    check("wait_ce_quiet", {31'd0, ce_seen}, 0);
    check("runA_mode_active", {31'd0, mode_active}, 0);
    $display("lock: running after %0d cycles", n);

    // R is the current cycle (offset 0)
    for (int off = 0; off <= 24; off++) begin
      if (off > 0) step();
      exp = 3'b000;
      foreach (tbl_a[k]) if (tbl_a[k].off == off) exp = tbl_a[k].ce;
      check($sformatf("tblA_ce_off%0d", off), {29'd0, ce}, {29'd0, exp});
      $display("vecA off=%0d ce=%b exp=%b", off, ce, exp);
    end

    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
      c2 += int'(ce[2]);
    end
    check("rate_ch2_3of8", c2, 300);
    check("rate_ch1_1of4", c1, 200);
    check("rate_ch0_1of12", c0, 66);
    $display("rate: ch0=%0d ch1=%0d ch2=%0d over 800 cycles", c0, c1, c2);

    // Offset now R+824; next ch0 boundary at R+828.
    step();
    mode_sel = 1'b1;
    n   = 0;
    bad = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ce[0]) begin
        n = i;
        break;
      end
      if (mode_active !== 1'b0 || running !== 1'b1) bad = 1'b1;
    end
    check("sw_wait_cycles", n, 3);
    check("sw_no_early_change", {31'd0, bad}, 0);
    check("sw_pulse_mode_active", {31'd0, mode_active}, 0);
    step();
    check("sw_cycle_ce", {29'd0, ce}, 0);
    check("sw_cycle_running", {31'd0, running}, 0);
    step();
    check("sw_done_pulse", {31'd0, switch_done}, 1);
    check("sw_mode_active", {31'd0, mode_active}, 1);
    check("sw_running", {31'd0, running}, 1);
    $display("switch: mode_active=%b switch_done=%b", mode_active, switch_done);

    for (int off = 0; off <= 20; off++) begin
      if (off > 0) step();
      exp = 3'b000;
      if (off > 0 && off % 5 == 0) exp[1] = 1'b1;
      if (off == 16) exp[0] = 1'b1;
      check($sformatf("tblB_ce_off%0d", off), {29'd0, ce}, {29'd0, exp});
      if (off == 1) check("sw_done_single", {31'd0, switch_done}, 0);
      $display("vecB off=%0d ce=%b exp=%b", off, ce, exp);
    end

    // Request A briefly, revert before the ch0 pulse at offset 32: switch must be cancelled.
    step();
    mode_sel = 1'b0;
    step();
    step();
    mode_sel = 1'b1;
    ce0_at = 0;
    bad    = 1'b0;
    for (int off = 24; off <= 34; off++) begin
      step();
      if (ce[0] && ce0_at == 0) ce0_at = off;
      if (mode_active !== 1'b1 || running !== 1'b1 || ce[2] !== 1'b0) bad = 1'b1;
    end
    check("cancel_ce0_offset", ce0_at, 32);
    check("cancel_no_switch", {31'd0, bad}, 0);
    $display("cancel: ce0 at offset %0d", ce0_at);

    pll_locked = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (!running && ce == 3'b000) begin
        n = i;
        break;
      end
    end
    check_range("unlock_latency", n, 1, 3);
    repeat (5) step();
    check("unlock_running", {31'd0, running}, 0);
    check("unlock_ce", {29'd0, ce}, 0);
    $display("unlock: stopped after %0d cycles", n);

    pll_locked = 1'b1;
    wait_running(n, ce_seen);
    check_range("relock_latency", n, 17, 19);
    check("relock_ce_quiet", {31'd0, ce_seen}, 0);
    check("relock_mode_active", {31'd0, mode_active}, 1);
    for (int off = 1; off <= 5; off++) begin
      step();
      exp = (off == 5) ? 3'b010 : 3'b000;
      check($sformatf("relock_ce_off%0d", off), {29'd0, ce}, {29'd0, exp});
    end
    $display("relock: running after %0d cycles, ce=%b", n, ce);

    // Async reset between clock edges while ce[1] is high.
    #1 rst_n = 1'b0;
    #1;
    check("areset_ce", {29'd0, ce}, 0);
    check("areset_running", {31'd0, running}, 0);
    check("areset_mode_active", {31'd0, mode_active}, 0);
    check("areset_switch_done", {31'd0, switch_done}, 0);
    $display("async reset: ce=%b running=%b mode_active=%b", ce, running, mode_active);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
